condinv_addsub_arbiter: RTL and testbench
=========================================

Name: condinv_addsub_arbiter

Overview:
Shares one conditional-inverter/adder datapath between two requesters. Each requester submits an add or subtract; the block arbitrates round-robin, sequences the datapath through invert and add stages, and returns a registered result with flags. Subtract is implemented as a + (~b) + 1: the operand is conditionally inverted (invert = op) and the carry-in is set to op. Sits between the execute-stage requesters and the shared ALU datapath.

Parameters:
WIDTH, 8, operand and result width in bits

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
req0  input  1  requester 0 operation request; held high until gnt0
op0  input  1  requester 0 operation: 0 = add, 1 = subtract
a0  input  WIDTH  requester 0 operand A
b0  input  WIDTH  requester 0 operand B (conditionally inverted)
req1  input  1  requester 1 operation request; held high until gnt1
op1  input  1  requester 1 operation
a1  input  WIDTH  requester 1 operand A
b1  input  WIDTH  requester 1 operand B
gnt0  output  1  combinational accept pulse for requester 0
gnt1  output  1  combinational accept pulse for requester 1
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse, result valid
owner  output  1  requester index of the current/last result
y  output  WIDTH  result
cout  output  1  carry out (for subtract: 1 = no borrow, a >= b unsigned)
zero  output  1  y == 0
ovf  output  1  signed overflow

Behaviour:
- Reset: synchronous, active-high, whenever sampled. Clock and reset ports are named clk and reset. State=IDLE; y=0, cout=0, zero=0, ovf=0, done=0, owner=0, busy=0; RR pointer last=1 (requester 0 favoured first). Reset mid-operation aborts; no done issued for the aborted op.
- FSM states: IDLE, INV, ADD, DONE.
- IDLE: if any req, gnt of the winner asserted combinationally this cycle; at the edge capture winner's a, b, op into internal registers, owner<=winner, last<=winner, go to INV. No req: stay IDLE. gnt0/gnt1 never high outside IDLE; never both high.
- Arbitration: only one req -> that one wins. Both -> winner = ~last (alternate).
- INV: register binv = op ? ~b : b, cin = op. Go to ADD.
- ADD: sum[WIDTH:0] = a + binv + cin (WIDTH+1 bits, wrap-around mod 2^WIDTH on y). At the edge register y=sum[WIDTH-1:0], cout=sum[WIDTH], zero=(y==0), ovf=(a[MSB]==binv[MSB]) && (y[MSB]!=a[MSB]). Go to DONE.
- DONE: done=1 for exactly this cycle; go to IDLE.
- Latency: grant in cycle T -> done in cycle T+3; next grant earliest T+4. Throughput one op per 4 cycles.
- y, flags and owner hold their values until the next ADD->DONE update.
- Requests arriving while busy are ignored until IDLE; a requester must keep req and operands stable until its gnt. Operand changes after gnt have no effect.

Test Plan:
- Reset: assert reset 2 cycles with req0=1 -> gnt0=0, y=0, done=0, busy=0 throughout; after release gnt0 in first IDLE cycle.
- Subtract equal: req0, op0=1, a0=0x88, b0=0x88 -> done at T+3, y=0x00, cout=1, zero=1, ovf=0, owner=0.
- Add with wrap: req1, op1=0, a1=0x88, b1=0x88 -> y=0x10, cout=1, zero=0, ovf=1, owner=1.
- Borrow case: op0=1, a0=0x00, b0=0x88 -> y=0x78, cout=0, ovf=0.
- Contention: req0 and req1 held continuously -> grants alternate 0,1,0,1 at cycles T, T+4, T+8, T+12, each followed by done 3 cycles later with the matching owner.
- Reset mid-op: assert reset in ADD state -> no done pulse, y=0, state IDLE next cycle, next contended grant goes to requester 0.

Source files
------------

// File: rtl/condinv_addsub_arbiter.sv
// -----------------------------------------------------------------------------
// condinv_addsub_arbiter
//
// Two requesters share one conditional-inverter / adder datapath. A request is
// granted round-robin while the block is idle. The operation then runs through
// an invert stage and an add stage, and a registered result is returned with
// flags. Subtract is computed as a + ~b + 1: operand B is inverted when op=1,
// and the carry-in equals op.
//
// Timing: grant in cycle T, INV in T+1, ADD in T+2, done pulse in T+3.
// The earliest next grant is in T+4.
//
// Ports:
//   clk                 system clock, rising edge
//   reset               synchronous, active-high reset
//   req0/op0/a0/b0      requester 0: request (held until gnt0), op (0 add,
//                       1 sub), operands
//   req1/op1/a1/b1      requester 1: same as requester 0
//   gnt0/gnt1           combinational accept pulses, only in IDLE, never both
//   busy                high in any state other than IDLE
//   done                one-cycle result-valid pulse
//   owner               requester index of the current/last result
//   y                   result (mod 2^WIDTH)
//   cout                carry out (subtract: 1 = no borrow)
//   zero                y == 0
//   ovf                 signed overflow
// -----------------------------------------------------------------------------
module condinv_addsub_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic             op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             owner,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             zero,
  output logic             ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INV  = 2'd1,
    S_ADD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic             last;      // requester granted most recently
  logic             winner;    // arbitration result for this cycle
  logic             grant;     // a grant is issued this cycle

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             op_q;
  logic [WIDTH-1:0] binv_q;
  logic             cin_q;

  logic [WIDTH:0]   sum;

  // ---------------------------------------------------------------------------
  // Arbitration. With a single requester, that requester wins. With both,
  // the winner alternates away from the last one granted. The grant is gated
  // by reset so that no request is accepted while reset is held.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    winner = 1'b0;
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    if (req0 && req1) begin
      winner = ~last;
    end else begin
      winner = req1;
    end
    if (state == S_IDLE && !reset && (req0 || req1)) begin
      gnt0 = ~winner;
      gnt1 = winner;
    end
  end

  assign grant = gnt0 | gnt1;

  // ---------------------------------------------------------------------------
  // FSM: state register plus next-state logic
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples pre-edge values no matter how the blocks are ordered.
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant) state_nxt = S_INV;
      S_INV:   state_nxt = S_ADD;
      S_ADD:   state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // ---------------------------------------------------------------------------
  // Operand pipeline. These registers are only read after being loaded in the
  // same operation, so they carry no reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: pure datapath registers are left unreset on purpose. The FSM
    // guarantees that each one is written before it is used.
    if (grant) begin
      a_q  <= winner ? a1  : a0;
      b_q  <= winner ? b1  : b0;
      op_q <= winner ? op1 : op0;
    end
    if (state == S_INV) begin
      binv_q <= op_q ? ~b_q : b_q;
      cin_q  <= op_q;
    end
  end

  assign sum = {1'b0, a_q} + {1'b0, binv_q} + {{WIDTH{1'b0}}, cin_q};

  // ---------------------------------------------------------------------------
  // Visible result, flags and arbitration history. These hold their values
  // until the next ADD stage.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      last  <= 1'b1;            // requester 0 is favoured first
      owner <= 1'b0;
      y     <= '0;
      cout  <= 1'b0;
      zero  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (grant) begin
        owner <= winner;
        last  <= winner;
      end
      if (state == S_ADD) begin
        y    <= sum[WIDTH-1:0];
        cout <= sum[WIDTH];
        zero <= (sum[WIDTH-1:0] == '0);
        // Overflow: both addends have the same sign and the result sign differs.
        ovf  <= (a_q[WIDTH-1] == binv_q[WIDTH-1]) &&
                (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
    end
  end

endmodule

// File: tb/tb_condinv_addsub_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for condinv_addsub_arbiter (WIDTH = 8).
// Stimulus pushes hand-computed expected results into a scoreboard queue.
// A monitor pops one entry on each done pulse and compares result, flags,
// owner and the done cycle (grant + 3).
// -----------------------------------------------------------------------------
module tb_condinv_addsub_arbiter;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic             req0, op0, req1, op1;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic             gnt0, gnt1, busy, done, owner, cout, zero, ovf;
  logic [WIDTH-1:0] y;

  typedef struct {
    logic             owner;
    logic [WIDTH-1:0] y;
    logic             cout;
    logic             zero;
    logic             ovf;
    int               cyc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  condinv_addsub_arbiter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .req0  (req0),
    .op0   (op0),
    .a0    (a0),
    .b0    (b0),
    .req1  (req1),
    .op1   (op1),
    .a1    (a1),
    .b1    (b1),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .busy  (busy),
    .done  (done),
    .owner (owner),
    .y     (y),
    .cout  (cout),
    .zero  (zero),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [WIDTH-1:0] ey, input logic ec,
                              input logic ez, input logic ev);
    exp_t e;
    e.owner = 1'b0;
    e.y     = ey;
    e.cout  = ec;
    e.zero  = ez;
    e.ovf   = ev;
    e.cyc   = 0;
    return e;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: grant sanity every cycle, and scoreboard compare on each done
  // ---------------------------------------------------------------------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("gnt_exclusive", 32'(gnt0 & gnt1), 32'd0);
        check("gnt_while_busy", 32'(busy & (gnt0 | gnt1)), 32'd0);
      end
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("done_cycle", 32'(cyc), 32'(e.cyc));
          check("owner", 32'(owner), 32'(e.owner));
          check("y", 32'(y), 32'(e.y));
          check("cout", 32'(cout), 32'(e.cout));
          check("zero", 32'(zero), 32'(e.zero));
          check("ovf", 32'(ovf), 32'(e.ovf));
        end
      end
    end
  end

  // Issue one operation, wait (bounded) for its grant, and push the expected
  // result. After the grant edge the operands are scrambled: they must no
  // longer affect the operation.
  task automatic do_op(input logic idx, input logic op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input exp_t e_in, output int gcyc);
    exp_t e;
    bit   got;
    e    = e_in;
    gcyc = -1;
    if (!idx) begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
    else      begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if (idx ? gnt1 : gnt0) got = 1'b1;
    end
    check("grant_seen", 32'(got), 32'd1);
    if (got) begin
      gcyc    = cyc;
      e.owner = idx;
      e.cyc   = cyc + 3;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!idx) begin req0 = 1'b0; op0 = ~op0; a0 = ~a0; b0 = 8'h5A; end
    else      begin req1 = 1'b0; op1 = ~op1; a1 = ~a1; b1 = 8'hA5; end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int gc;
    int rc;
    int t0;
    bit got;

    reset = 1'b1;
    req0 = 1'b1; op0 = 1'b1; a0 = 8'h88; b0 = 8'h88;
    req1 = 1'b0; op1 = 1'b0; a1 = 8'h00; b1 = 8'h00;

    // Reset held with req0 high: no grant, idle, result cleared.
    @(posedge clk);
    @(negedge clk);
    check("rst_gnt0", 32'(gnt0), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    @(posedge clk);
    #1;
    check("rst_gnt0_b", 32'(gnt0), 32'd0);
    check("rst_y_b", 32'(y), 32'd0);
    reset = 1'b0;
    rc = cyc;

    // First idle cycle after reset: immediate grant. 0x88 - 0x88.
    do_op(1'b0, 1'b1, 8'h88, 8'h88, mk(8'h00, 1'b1, 1'b1, 1'b0), gc);
    check("grant_after_reset_cycle", 32'(gc), 32'(rc));
    // 0x88 + 0x88 = 0x110: wraps, signed overflow.
    do_op(1'b1, 1'b0, 8'h88, 8'h88, mk(8'h10, 1'b1, 1'b0, 1'b1), gc);
    // 0x00 - 0x88: borrow.
    do_op(1'b0, 1'b1, 8'h00, 8'h88, mk(8'h78, 1'b0, 1'b0, 1'b0), gc);
    // 0x7F + 0x01: positive overflow.
    do_op(1'b1, 1'b0, 8'h7F, 8'h01, mk(8'h80, 1'b0, 1'b0, 1'b1), gc);
    // 0x80 - 0x01: negative overflow, no borrow.
    do_op(1'b0, 1'b1, 8'h80, 8'h01, mk(8'h7F, 1'b1, 1'b0, 1'b1), gc);
    // 0xFF + 0x01: carry out, zero.
    do_op(1'b1, 1'b0, 8'hFF, 8'h01, mk(8'h00, 1'b1, 1'b1, 1'b0), gc);
    // 0x03 - 0x05 = 0xFE: borrow, leaves a nonzero result behind.
    do_op(1'b1, 1'b1, 8'h03, 8'h05, mk(8'hFE, 1'b0, 1'b0, 1'b0), gc);
    repeat (4) @(posedge clk);
    #1;

    // Reset during ADD of a requester-0 op: no done, y cleared, and the
    // pointer returns to favouring requester 0.
    req0 = 1'b1; op0 = 1'b0; a0 = 8'h11; b0 = 8'h22;
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if (gnt0) got = 1'b1;
    end
    check("abort_grant_seen", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    req0 = 1'b0;                       // now in INV
    @(posedge clk);
    #1;                                // now in ADD
    check("abort_busy_in_add", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    req0 = 1'b1; op0 = 1'b1; a0 = 8'h05; b0 = 8'h03;
    req1 = 1'b1; op1 = 1'b0; a1 = 8'h40; b1 = 8'h40;
    @(negedge clk);
    check("abort_y", 32'(y), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);

    // Contention: both requests held, so grants alternate 0,1,0,1 every
    // 4 cycles, starting with requester 0.
    t0 = 0;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int i = 0; i < 10; i++) begin
        if (gnt0 || gnt1) begin
          got = 1'b1;
          break;
        end
        @(negedge clk);
      end
      check("cont_grant_seen", 32'(got), 32'd1);
      if (!got) break;
      if (k == 0) t0 = cyc;
      check("cont_winner", 32'(gnt1), 32'(k % 2));
      check("cont_grant_cycle", 32'(cyc), 32'(t0 + 4 * k));
      begin
        exp_t e;
        if (gnt1) e = mk(8'h80, 1'b0, 1'b0, 1'b1);   // 0x40 + 0x40
        else      e = mk(8'h02, 1'b1, 1'b0, 1'b0);   // 0x05 - 0x03
        e.owner = gnt1;
        e.cyc   = cyc + 3;
        sb.push_back(e);
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    req0 = 1'b0;
    req1 = 1'b0;

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
